// File: rtl/bxb_dma_pkg.sv
// Shared types and default widths for the Bxb DMA read path.
// The tag layout here matches the default build (up to 4 requesters, 10-bit burstcount).
package bxb_dma_pkg;

   localparam int unsigned BXB_ADDR_W  = 32;
   localparam int unsigned BXB_BURST_W = 10;
   localparam int unsigned BXB_DATA_W  = 64;

   typedef enum logic [0:0] {
      StIdle,
      StIssue
   } arb_state_e;

   typedef struct packed {
      logic [1:0]             id;
      logic [BXB_BURST_W-1:0] burst;
   } bxb_tag_t;

endpackage

// File: rtl/bxb_tag_fifo.sv
// In-order tag FIFO for outstanding read bursts; first-word-fall-through head.
// DEPTH must be a power of two so the pointers wrap naturally.
module bxb_tag_fifo #(
   parameter int unsigned WIDTH = 12,
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  count_q, count_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == CntW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];

   always_comb begin
      do_push  = push_i && (!full_o || pop_i);
      do_pop   = pop_i && !empty_o;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      if (do_push && !do_pop) begin
         count_d = count_q + CntW'(1);
      end else if (do_pop && !do_push) begin
         count_d = count_q - CntW'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: entries are only read when count says they are valid.
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

endmodule

// File: rtl/bxb_rd_arbiter.sv
// Shares one Avalon-MM burst read master among NUM_REQ requesters with per-burst round-robin
// arbitration; return beats are steered to their owner through an in-order tag FIFO.
module bxb_rd_arbiter
   import bxb_dma_pkg::*;
#(
   parameter int unsigned NUM_REQ   = 3,
   parameter int unsigned ADDR_W    = BXB_ADDR_W,
   parameter int unsigned BURST_W   = BXB_BURST_W,
   parameter int unsigned DATA_W    = BXB_DATA_W,
   parameter int unsigned MAX_OUTST = 8
) (
   input  logic                       bxb_clock,
   input  logic                       bxb_reset,
   input  logic [NUM_REQ-1:0]         s_read,
   input  logic [NUM_REQ*ADDR_W-1:0]  s_address,
   input  logic [NUM_REQ*BURST_W-1:0] s_burstcount,
   output logic [NUM_REQ-1:0]         s_waitrequest,
   output logic [NUM_REQ-1:0]         s_readdatavalid,
   output logic [DATA_W-1:0]          s_readdata,
   output logic [ADDR_W-1:0]          m_address,
   output logic [BURST_W-1:0]         m_burstcount,
   output logic                       m_read,
   input  logic                       m_waitrequest,
   input  logic                       m_readdatavalid,
   input  logic [DATA_W-1:0]          m_readdata,
   output logic                       err_sticky
);

   localparam int unsigned IdW  = $clog2(NUM_REQ);
   localparam int unsigned CntW = $clog2(MAX_OUTST) + 1;

   typedef struct packed {
      logic [IdW-1:0]     id;
      logic [BURST_W-1:0] burst;
   } tag_t;

   arb_state_e          state_q, state_d;
   logic [IdW-1:0]      rr_q, rr_d;
   logic [ADDR_W-1:0]   m_address_q, m_address_d;
   logic [BURST_W-1:0]  m_burstcount_q, m_burstcount_d;
   logic [BURST_W-1:0]  beat_q, beat_d;
   logic [NUM_REQ-1:0]  s_readdatavalid_q, s_readdatavalid_d;
   logic [DATA_W-1:0]   s_readdata_q, s_readdata_d;
   logic                err_q, err_d;

   logic [IdW-1:0]      cand, win_id;
   logic                win_vld, grant, accept;
   logic [ADDR_W-1:0]   sel_addr;
   logic [BURST_W-1:0]  sel_bc, cur_beats;
   logic                push, pop, fifo_full, fifo_empty;
   logic [CntW-1:0]     fifo_cnt;
   tag_t                push_tag, head_tag;

   // Scan downward so the last hit is the first asserted index after the rr pointer.
   always_comb begin
      cand     = '0;
      win_id   = '0;
      win_vld  = 1'b0;
      sel_addr = '0;
      sel_bc   = '0;
      for (int i = int'(NUM_REQ); i >= 1; i--) begin
         cand = IdW'((int'(rr_q) + i) % int'(NUM_REQ));
         if (s_read[cand]) begin
            win_vld = 1'b1;
            win_id  = cand;
         end
      end
      for (int j = 0; j < int'(NUM_REQ); j++) begin
         if (win_id == IdW'(j)) begin
            sel_addr = s_address[j*ADDR_W +: ADDR_W];
            sel_bc   = s_burstcount[j*BURST_W +: BURST_W];
         end
      end
   end

   // Space is reserved at grant time, so a burst in ISSUE can always be pushed.
   assign grant  = (state_q == StIdle) && win_vld && (fifo_cnt < CntW'(MAX_OUTST));
   assign accept = (state_q == StIssue) && !m_waitrequest;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (grant)  state_d = StIssue;
         StIssue: if (accept) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      rr_d           = grant ? win_id   : rr_q;
      m_address_d    = grant ? sel_addr : m_address_q;
      m_burstcount_d = grant ? sel_bc   : m_burstcount_q;
   end

   always_comb begin
      m_read         = (state_q == StIssue);
      push           = accept && (m_burstcount_q != '0) && !fifo_full;
      push_tag.id    = rr_q;
      push_tag.burst = m_burstcount_q;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         s_waitrequest[i] = !(grant && (win_id == IdW'(i)));
      end
   end

   always_comb begin
      pop               = 1'b0;
      beat_d            = beat_q;
      cur_beats         = (beat_q == '0) ? head_tag.burst : beat_q;
      s_readdatavalid_d = '0;
      s_readdata_d      = s_readdata_q;
      err_d             = err_q;
      if (accept && (m_burstcount_q == '0)) begin
         err_d = 1'b1;
      end
      if (m_readdatavalid) begin
         if (fifo_empty) begin
            err_d = 1'b1;
         end else begin
            for (int i = 0; i < int'(NUM_REQ); i++) begin
               s_readdatavalid_d[i] = (head_tag.id == IdW'(i));
            end
            s_readdata_d = m_readdata;
            if (cur_beats == BURST_W'(1)) begin
               pop    = 1'b1;
               beat_d = '0;
            end else begin
               beat_d = cur_beats - BURST_W'(1);
            end
         end
      end
   end

   always_ff @(posedge bxb_clock or posedge bxb_reset) begin
      if (bxb_reset) begin
         state_q           <= StIdle;
         rr_q              <= IdW'(NUM_REQ - 1);
         m_address_q       <= '0;
         m_burstcount_q    <= '0;
         beat_q            <= '0;
         s_readdatavalid_q <= '0;
         s_readdata_q      <= '0;
         err_q             <= 1'b0;
      end else begin
         state_q           <= state_d;
         rr_q              <= rr_d;
         m_address_q       <= m_address_d;
         m_burstcount_q    <= m_burstcount_d;
         beat_q            <= beat_d;
         s_readdatavalid_q <= s_readdatavalid_d;
         s_readdata_q      <= s_readdata_d;
         err_q             <= err_d;
      end
   end

   assign m_address       = m_address_q;
   assign m_burstcount    = m_burstcount_q;
   assign s_readdatavalid = s_readdatavalid_q;
   assign s_readdata      = s_readdata_q;
   assign err_sticky      = err_q;

   bxb_tag_fifo #(
      .WIDTH (IdW + BURST_W),
      .DEPTH (MAX_OUTST)
   ) u_tag_fifo (
      .clk_i   (bxb_clock),
      .rst_i   (bxb_reset),
      .push_i  (push),
      .wdata_i (push_tag),
      .pop_i   (pop),
      .rdata_o (head_tag),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_cnt)
   );

endmodule

// File: tb/tb_bxb_rd_arbiter.sv
// Directed bench for bxb_rd_arbiter: single burst, contention, back-to-back returns,
// backpressure, FIFO full, error cases and reset mid-burst.
module tb_bxb_rd_arbiter;

   logic        bxb_clock = 1'b0;
   logic        bxb_reset;
   logic [2:0]  s_read;
   logic [95:0] s_address;
   logic [29:0] s_burstcount;
   logic [2:0]  s_waitrequest;
   logic [2:0]  s_readdatavalid;
   logic [63:0] s_readdata;
   logic [31:0] m_address;
   logic [9:0]  m_burstcount;
   logic        m_read;
   logic        m_waitrequest;
   logic        m_readdatavalid;
   logic [63:0] m_readdata;
   logic        err_sticky;

   int          errors = 0;
   int          checks = 0;
   logic [2:0]  exp3;
   logic [2:0]  exp_b [5];

   bxb_rd_arbiter dut (
      .bxb_clock       (bxb_clock),
      .bxb_reset       (bxb_reset),
      .s_read          (s_read),
      .s_address       (s_address),
      .s_burstcount    (s_burstcount),
      .s_waitrequest   (s_waitrequest),
      .s_readdatavalid (s_readdatavalid),
      .s_readdata      (s_readdata),
      .m_address       (m_address),
      .m_burstcount    (m_burstcount),
      .m_read          (m_read),
      .m_waitrequest   (m_waitrequest),
      .m_readdatavalid (m_readdatavalid),
      .m_readdata      (m_readdata),
      .err_sticky      (err_sticky)
   );

   always #5 bxb_clock = ~bxb_clock;

   task automatic step();
      @(posedge bxb_clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int i, input logic [31:0] a, input logic [9:0] bc);
      s_address[i*32 +: 32]   = a;
      s_burstcount[i*10 +: 10] = bc;
   endtask

   initial begin
      bxb_reset       = 1'b1;
      s_read          = '0;
      s_address       = '0;
      s_burstcount    = '0;
      m_waitrequest   = 1'b0;
      m_readdatavalid = 1'b0;
      m_readdata      = '0;
      step();
      step();
      chk("rst_mread", m_read, 0);
      chk("rst_maddr", m_address, 0);
      chk("rst_mbc", m_burstcount, 0);
      chk("rst_wr", s_waitrequest, 3'b111);
      chk("rst_rdv", s_readdatavalid, 0);
      chk("rst_rdata", s_readdata, 0);
      chk("rst_err", err_sticky, 0);
      bxb_reset = 1'b0;

      // Single burst: r0 0x1000 bc 4
      set_req(0, 32'h1000, 10'd4);
      s_read = 3'b001;
      #1;
      chk("t1_wr_grant", s_waitrequest, 3'b110);
      chk("t1_mread_pre", m_read, 0);
      step();
      s_read = 3'b000;
      #1;
      chk("t1_mread", m_read, 1);
      chk("t1_maddr", m_address, 32'h1000);
      chk("t1_mbc", m_burstcount, 4);
      chk("t1_wr_issue", s_waitrequest, 3'b111);
      step();
      chk("t1_mread_done", m_read, 0);
      for (int k = 0; k < 4; k++) begin
         m_readdatavalid = 1'b1;
         m_readdata      = 64'hA000 + 64'(k);
         #1;
         if (k == 0) chk("t1_rdv_latency", s_readdatavalid, 0);
         step();
         chk("t1_rdv", s_readdatavalid, 3'b001);
         chk("t1_rdata", s_readdata, 64'hA000 + 64'(k));
      end
      m_readdatavalid = 1'b0;
      step();
      chk("t1_rdv_end", s_readdatavalid, 0);

      // Contention: reset restores rr pointer to 2, so grants go 0,1,2,0,1,2
      bxb_reset = 1'b1;
      step();
      bxb_reset = 1'b0;
      for (int i = 0; i < 3; i++) set_req(i, 32'h100 * 32'(i + 1), 10'd1);
      s_read = 3'b111;
      #1;
      for (int g = 0; g < 6; g++) begin
         exp3 = 3'b001 << (g % 3);
         exp3 = ~exp3;
         chk("t2_wr_grant", s_waitrequest, exp3);
         step();
         chk("t2_wr_issue", s_waitrequest, 3'b111);
         chk("t2_maddr", m_address, 32'h100 * 32'((g % 3) + 1));
         if (g == 5) s_read = 3'b000;
         step();
         #1;
      end
      m_readdatavalid = 1'b1;
      for (int k = 0; k < 6; k++) begin
         m_readdata = 64'hB0 + 64'(k);
         step();
         exp3 = 3'b001 << (k % 3);
         chk("t2_rdv", s_readdatavalid, exp3);
         chk("t2_rdata", s_readdata, 64'hB0 + 64'(k));
      end
      m_readdatavalid = 1'b0;
      step();
      chk("t2_rdv_end", s_readdatavalid, 0);
      chk("t2_err", err_sticky, 0);

      // Back-to-back returns: r0 bc 2 then r2 bc 3
      set_req(0, 32'h3000, 10'd2);
      s_read = 3'b001;
      #1;
      chk("t3_wr_r0", s_waitrequest, 3'b110);
      step();
      s_read = 3'b000;
      step();
      set_req(2, 32'h4000, 10'd3);
      s_read = 3'b100;
      #1;
      chk("t3_wr_r2", s_waitrequest, 3'b011);
      step();
      s_read = 3'b000;
      step();
      exp_b = '{3'b001, 3'b001, 3'b100, 3'b100, 3'b100};
      m_readdatavalid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         m_readdata = 64'hC0 + 64'(k);
         step();
         chk("t3_rdv", s_readdatavalid, exp_b[k]);
      end
      m_readdatavalid = 1'b0;
      step();
      chk("t3_rdv_end", s_readdatavalid, 0);

      // Backpressure: r1 0x2000 bc 5, slave stalls 7 cycles
      m_waitrequest = 1'b1;
      set_req(1, 32'h2000, 10'd5);
      s_read = 3'b010;
      #1;
      chk("t4_wr_grant", s_waitrequest, 3'b101);
      step();
      s_read = 3'b000;
      set_req(1, 32'h5555, 10'd7);
      #1;
      for (int c = 0; c < 7; c++) begin
         chk("t4_mread_hold", m_read, 1);
         chk("t4_maddr_hold", m_address, 32'h2000);
         chk("t4_mbc_hold", m_burstcount, 5);
         step();
         #1;
      end
      m_waitrequest = 1'b0;
      #1;
      chk("t4_mread_rel", m_read, 1);
      step();
      chk("t4_mread_done", m_read, 0);
      m_readdatavalid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         m_readdata = 64'hD0 + 64'(k);
         step();
         chk("t4_rdv", s_readdatavalid, 3'b010);
      end
      m_readdatavalid = 1'b0;
      step();

      // Full: 8 bursts with no return data, 9th must wait for a pop
      set_req(0, 32'h6000, 10'd1);
      s_read = 3'b001;
      #1;
      for (int g = 0; g < 8; g++) begin
         chk("t5_wr_grant", s_waitrequest, 3'b110);
         step();
         step();
         #1;
      end
      chk("t5_wr_full", s_waitrequest, 3'b111);
      step();
      chk("t5_wr_full2", s_waitrequest, 3'b111);
      chk("t5_mread_full", m_read, 0);
      m_readdatavalid = 1'b1;
      m_readdata      = 64'h77;
      #1;
      chk("t5_wr_full3", s_waitrequest, 3'b111);
      step();
      m_readdatavalid = 1'b0;
      #1;
      chk("t5_rdv_pop", s_readdatavalid, 3'b001);
      chk("t5_wr_release", s_waitrequest, 3'b110);
      step();
      s_read = 3'b000;
      step();
      m_readdatavalid = 1'b1;
      for (int k = 0; k < 8; k++) begin
         m_readdata = 64'hE0 + 64'(k);
         step();
         chk("t5_rdv_drain", s_readdatavalid, 3'b001);
      end
      m_readdatavalid = 1'b0;
      step();
      chk("t5_err", err_sticky, 0);

      // Errors: beat with FIFO empty
      m_readdatavalid = 1'b1;
      m_readdata      = 64'hF0;
      step();
      m_readdatavalid = 1'b0;
      #1;
      chk("t6_rdv_drop", s_readdatavalid, 0);
      chk("t6_err_empty", err_sticky, 1);
      bxb_reset = 1'b1;
      #1;
      chk("t6_err_rst", err_sticky, 0);
      step();
      bxb_reset = 1'b0;
      // r1 with burstcount 0: issued but not tagged
      set_req(1, 32'h7000, 10'd0);
      s_read = 3'b010;
      #1;
      chk("t6_wr_bc0", s_waitrequest, 3'b101);
      step();
      s_read = 3'b000;
      #1;
      chk("t6_mread_bc0", m_read, 1);
      chk("t6_err_pre", err_sticky, 0);
      step();
      chk("t6_err_bc0", err_sticky, 1);
      chk("t6_mread_done", m_read, 0);
      m_readdatavalid = 1'b1;
      step();
      m_readdatavalid = 1'b0;
      #1;
      chk("t6_rdv_nopush", s_readdatavalid, 0);

      // Reset mid-burst
      bxb_reset = 1'b1;
      step();
      bxb_reset = 1'b0;
      set_req(2, 32'h8000, 10'd4);
      s_read = 3'b100;
      #1;
      chk("t7_wr_r2", s_waitrequest, 3'b011);
      step();
      s_read = 3'b000;
      step();
      m_readdatavalid = 1'b1;
      m_readdata      = 64'h99;
      step();
      m_readdatavalid = 1'b0;
      #1;
      chk("t7_rdv", s_readdatavalid, 3'b100);
      m_waitrequest = 1'b1;
      set_req(0, 32'h9000, 10'd2);
      s_read = 3'b001;
      step();
      s_read = 3'b000;
      #1;
      chk("t7_mread_pre", m_read, 1);
      #2;
      bxb_reset = 1'b1;
      #1;
      chk("t7_rst_mread", m_read, 0);
      chk("t7_rst_maddr", m_address, 0);
      chk("t7_rst_mbc", m_burstcount, 0);
      chk("t7_rst_rdv", s_readdatavalid, 0);
      chk("t7_rst_rdata", s_readdata, 0);
      chk("t7_rst_wr", s_waitrequest, 3'b111);
      chk("t7_rst_err", err_sticky, 0);
      step();
      bxb_reset       = 1'b0;
      m_waitrequest   = 1'b0;
      m_readdatavalid = 1'b1;
      step();
      m_readdatavalid = 1'b0;
      #1;
      chk("t7_tags_discarded", err_sticky, 1);
      chk("t7_rdv_drop", s_readdatavalid, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
